pick_motion_ctrl: RTL
=====================

Name: pick_motion_ctrl

Overview:
Upstream stage of every lock level. It converts the USB keyboard keycode into the pick position (pickY, pickLRx) and the tension-wrench signal (openner) that the level checker consumes. Motion is frame-paced: position updates exactly once per video frame, driven by a frame strobe resynchronised into Clk. A small FSM freezes motion while the wrench is turned.

Parameters:
STEP, 2, pixels moved per frame per held direction key
Y_MIN, 32, lowest legal pickY (top pin slot)
Y_MAX, 479, highest legal pickY
X_MIN, 100, leftmost legal pickLRx (deepest insertion)
X_MAX, 600, rightmost legal pickLRx (pick withdrawn)
Y_HOME, 256, pickY after reset or disable
TURN_FRAMES, 8, frames openner is forced high and motion frozen after Space press

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
enable  in  1  level active (same strobe as the level start signal)
frame_tick  in  1  raw vsync-derived level, asynchronous to Clk
keycode  in  8  current USB HID keycode, 0x00 = none
pickY  out  10  pick vertical position
pickLRx  out  10  pick horizontal position
openner  out  1  tension wrench applied
busy_turn  out  1  high while in TURN state

Behaviour:
- Reset (Reset_n low, async): pickY=Y_HOME, pickLRx=X_MAX, openner=0, busy_turn=0, state=IDLE, frame counter=0.
- frame_tick: 2-flop synchroniser, then rising-edge detect, giving a 1-Clk pulse `fstep`. Positions and counters change only on cycles where fstep=1. Latency: outputs update 3 Clk after the frame_tick rising edge.
- Keycodes are fixed: 0x1A up (pickY-STEP), 0x16 down (pickY+STEP), 0x04 left (pickLRx-STEP), 0x07 right (pickLRx+STEP), 0x2C Space. Any other code means no motion.
- Arithmetic: computed 11-bit signed, then clamped to [Y_MIN,Y_MAX] or [X_MIN,X_MAX]. No wrap-around. At the bound, the position holds.
- FSM:
  - IDLE: outputs at home values and openner=0. Moves to PROBE on the first fstep with enable=1.
  - PROBE: applies direction keys on each fstep. On an fstep where keycode=0x2C, goes to TURN: openner=1, counter=0, no motion that frame.
  - TURN: openner=1, busy_turn=1, keys ignored. Counter increments each fstep. When counter reaches TURN_FRAMES-1 on an fstep, goes to SETTLE.
  - SETTLE: openner=1, no motion. On the first fstep with keycode!=0x2C, goes to PROBE and openner=0 that same cycle.
- enable low in any state: on the next Clk edge (not fstep-gated), go to IDLE and restore home values. A TURN in progress is abandoned and openner drops.
- Reset mid-TURN: immediate return to reset values.
- Only one keycode exists, so simultaneous directions cannot occur.

Optional Feature:
PICK_ACCEL_EN
- Defined: a 3-bit hold counter counts consecutive fsteps with the same direction keycode. Once it saturates at 7, the step becomes 2*STEP. Clamping still applies. The counter clears on a key change, on leaving PROBE, or on reset.
- Undefined: step is always STEP and no hold counter exists.

Decomposition:
- Shared package pick_pkg:
  - keycode constants KEY_UP/DOWN/LEFT/RIGHT/SPACE
  - default bound constants
  - state enum pick_state_t {IDLE, PROBE, TURN, SETTLE}
- One sub-module: frame_tick_sync (2-flop synchroniser plus rising-edge pulse). The level checker and other frame-paced blocks reuse it.

Test Plan:
- Reset, then enable=1, one frame_tick with keycode 0x00 -> PROBE; pickY=256, pickLRx=600, openner=0.
- keycode 0x1A held for 120 frames -> pickY steps 256,254,... and clamps at 32 from frame 112 onward, with no wrap to 1023.
- keycode 0x04 held for 10 frames -> pickLRx=580. Frame_tick held high for many Clk -> only one step per rising edge.
- Space for 1 frame, then 0x16 for 12 frames -> openner=1 and pickY frozen for 8 frames, SETTLE exits on frame 9, pickY then moves +2 per frame.
- enable dropped during TURN (frame 4) -> next Clk: openner=0, busy_turn=0, pickY=256, pickLRx=600, state IDLE.
- With PICK_ACCEL_EN defined: 0x07 held from pickLRx=500 -> +2 per frame for 7 frames, then +4 per frame, clamped at 600.

Source files
------------

// File: rtl/pick_motion_ctrl_pkg.sv
// pick_pkg: shared keycodes, default bounds, FSM state type and clamp helper
// for the pick motion block and its frame-paced neighbours.
package pick_pkg;

   localparam logic [7:0] KEY_NONE  = 8'h00;
   localparam logic [7:0] KEY_UP    = 8'h1A;
   localparam logic [7:0] KEY_DOWN  = 8'h16;
   localparam logic [7:0] KEY_LEFT  = 8'h04;
   localparam logic [7:0] KEY_RIGHT = 8'h07;
   localparam logic [7:0] KEY_SPACE = 8'h2C;

   localparam int unsigned DEF_STEP        = 2;
   localparam int unsigned DEF_Y_MIN       = 32;
   localparam int unsigned DEF_Y_MAX       = 479;
   localparam int unsigned DEF_X_MIN       = 100;
   localparam int unsigned DEF_X_MAX       = 600;
   localparam int unsigned DEF_Y_HOME      = 256;
   localparam int unsigned DEF_TURN_FRAMES = 8;

   typedef enum logic [1:0] {
      IDLE,
      PROBE,
      TURN,
      SETTLE
   } pick_state_t;

   // Signed 11-bit add, then saturate into [lo,hi]; a position never wraps.
   function automatic logic [9:0] clamp_pos(input logic [9:0]         pos,
                                            input logic signed [10:0] delta,
                                            input logic [9:0]         lo,
                                            input logic [9:0]         hi);
      logic signed [10:0] sum;
      sum = $signed({1'b0, pos}) + delta;
      if (sum < $signed({1'b0, lo}))
         return lo;
      else if (sum > $signed({1'b0, hi}))
         return hi;
      else
         return sum[9:0];
   endfunction

endpackage

// File: rtl/pick_motion_ctrl_if.sv
// pick_motion_ctrl_if: level-control inputs and pick position/wrench outputs
// of the pick motion block, grouped as one bus.
interface pick_motion_ctrl_if;
   logic       enable;
   logic       frame_tick;
   logic [7:0] keycode;
   logic [9:0] pickY;
   logic [9:0] pickLRx;
   logic       openner;
   logic       busy_turn;

   modport master (
      output enable, frame_tick, keycode,
      input  pickY, pickLRx, openner, busy_turn
   );

   modport slave (
      input  enable, frame_tick, keycode,
      output pickY, pickLRx, openner, busy_turn
   );
endinterface

// File: rtl/pick_motion_ctrl_sync.sv
// frame_tick_sync: 2-flop synchroniser for the asynchronous frame strobe plus
// rising-edge detect giving a single-Clk pulse per frame.
module frame_tick_sync (
   input  logic Clk,
   input  logic Reset_n,
   input  logic tick_async,
   output logic fstep
);
   logic [2:0] sr;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)
         sr <= '0;
      else
         sr <= {sr[1:0], tick_async};
   end

   // sr[1] is the synchronised level; sr[2] is its previous value.
   assign fstep = sr[1] & ~sr[2];
endmodule

// File: rtl/pick_motion_ctrl.sv
// pick_motion_ctrl: keycode -> frame-paced pick position and tension-wrench FSM.
// Optional PICK_ACCEL_EN: step doubles after 7 consecutive frames on one direction key.
module pick_motion_ctrl
   import pick_pkg::*;
#(
   parameter int unsigned STEP        = DEF_STEP,
   parameter int unsigned Y_MIN       = DEF_Y_MIN,
   parameter int unsigned Y_MAX       = DEF_Y_MAX,
   parameter int unsigned X_MIN       = DEF_X_MIN,
   parameter int unsigned X_MAX       = DEF_X_MAX,
   parameter int unsigned Y_HOME      = DEF_Y_HOME,
   parameter int unsigned TURN_FRAMES = DEF_TURN_FRAMES
) (
   input  logic              Clk,
   input  logic              Reset_n,
   pick_motion_ctrl_if.slave bus
);
   localparam int unsigned        CW       = (TURN_FRAMES > 2) ? $clog2(TURN_FRAMES) : 1;
   localparam logic [CW-1:0]      CNT_LAST = CW'(TURN_FRAMES - 1);
   localparam logic [9:0]         YMIN_V   = 10'(Y_MIN);
   localparam logic [9:0]         YMAX_V   = 10'(Y_MAX);
   localparam logic [9:0]         XMIN_V   = 10'(X_MIN);
   localparam logic [9:0]         XMAX_V   = 10'(X_MAX);
   localparam logic [9:0]         YHOME_V  = 10'(Y_HOME);
   localparam logic signed [10:0] STEP_V   = $signed(11'(STEP));

   pick_state_t        state, state_nx;
   logic [9:0]         y_q, y_nx, x_q, x_nx;
   logic [CW-1:0]      cnt_q, cnt_nx;
   logic signed [10:0] step;
   logic               fstep;
   logic               is_dir;
`ifdef PICK_ACCEL_EN
   logic [2:0]         hold_q, hold_nx;
   logic [7:0]         last_q, last_nx;
`endif

   frame_tick_sync u_sync (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .tick_async (bus.frame_tick),
      .fstep      (fstep)
   );

   assign is_dir = (bus.keycode == KEY_UP)   || (bus.keycode == KEY_DOWN) ||
                   (bus.keycode == KEY_LEFT) || (bus.keycode == KEY_RIGHT);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state  <= IDLE;
         y_q    <= YHOME_V;
         x_q    <= XMAX_V;
         cnt_q  <= '0;
`ifdef PICK_ACCEL_EN
         hold_q <= '0;
         last_q <= KEY_NONE;
`endif
      end else begin
         state  <= state_nx;
         y_q    <= y_nx;
         x_q    <= x_nx;
         cnt_q  <= cnt_nx;
`ifdef PICK_ACCEL_EN
         hold_q <= hold_nx;
         last_q <= last_nx;
`endif
      end
   end

   always_comb begin
      state_nx = state;
      y_nx     = y_q;
      x_nx     = x_q;
      cnt_nx   = cnt_q;
      step     = STEP_V;
`ifdef PICK_ACCEL_EN
      hold_nx  = hold_q;
      last_nx  = last_q;
`endif
      // Disable is level-sensitive and overrides frame pacing.
      if (!bus.enable) begin
         state_nx = IDLE;
         y_nx     = YHOME_V;
         x_nx     = XMAX_V;
         cnt_nx   = '0;
      end else if (fstep) begin
         case (state)
            IDLE:   state_nx = PROBE;
            PROBE: begin
               if (bus.keycode == KEY_SPACE) begin
                  state_nx = TURN;
                  cnt_nx   = '0;
               end else begin
`ifdef PICK_ACCEL_EN
                  if (is_dir && (bus.keycode == last_q) && (hold_q == 3'd7))
                     step = STEP_V + STEP_V;
`endif
                  case (bus.keycode)
                     KEY_UP:    y_nx = clamp_pos(y_q, -step, YMIN_V, YMAX_V);
                     KEY_DOWN:  y_nx = clamp_pos(y_q,  step, YMIN_V, YMAX_V);
                     KEY_LEFT:  x_nx = clamp_pos(x_q, -step, XMIN_V, XMAX_V);
                     KEY_RIGHT: x_nx = clamp_pos(x_q,  step, XMIN_V, XMAX_V);
                     default:   ;
                  endcase
               end
            end
            TURN: begin
               if (cnt_q == CNT_LAST)
                  state_nx = SETTLE;
               else
                  cnt_nx = cnt_q + 1'b1;
            end
            SETTLE: begin
               if (bus.keycode != KEY_SPACE)
                  state_nx = PROBE;
            end
            default: state_nx = IDLE;
         endcase
      end

`ifdef PICK_ACCEL_EN
      // Only PROBE frames on a direction key build the run; anything else clears it.
      if (!bus.enable || (fstep && (state == PROBE) && !is_dir)) begin
         hold_nx = '0;
         last_nx = KEY_NONE;
      end else if (fstep && (state == PROBE)) begin
         if (bus.keycode == last_q)
            hold_nx = (hold_q == 3'd7) ? hold_q : hold_q + 3'd1;
         else
            hold_nx = 3'd1;
         last_nx = bus.keycode;
      end
`endif
   end

   assign bus.pickY     = y_q;
   assign bus.pickLRx   = x_q;
   assign bus.openner   = (state == TURN) || (state == SETTLE);
   assign bus.busy_turn = (state == TURN);

endmodule
